sipo_rx_ctrl: RTL
=================

SIPO_RX_CTRL -- requirements
Module: sipo_rx_ctrl

Interface
REQ-001 SHALL have parameter N, default 10, meaning data bits per frame (1..15).
REQ-002 SHALL have parameter DIV, default 16, meaning clock cycles per serial bit (even, >= 4).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port res, input, 1, synchronous active-low reset (res==0 at a clk edge resets).
REQ-005 SHALL have port rx, input, 1, asynchronous serial line: idle high, start 0, N data bits LSB first, stop 1.
REQ-006 SHALL have port ack, input, 1, consumer accepts out when asserted with valid.
REQ-007 SHALL have port out, output, N, last good frame's data.
REQ-008 SHALL have port valid, output, 1, out holds an unconsumed frame.
REQ-009 SHALL have port busy, output, 1, high whenever state != IDLE.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse on bad stop bit.
REQ-011 SHALL have port overrun, output, 1, one-cycle pulse when a good frame is dropped.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; all timing below refers to synchronized rx (rxs).
REQ-013 States SHALL be IDLE, START, SHIFT, STOP, WAIT_IDLE.
REQ-014 IDLE: first cycle with rxs==0 (t0) -> START, tick counter cleared.
REQ-015 START: at t0+DIV/2, rxs==0 -> SHIFT (bit counter 0, tick 0); rxs==1 -> IDLE (glitch, no outputs).
REQ-016 SHIFT: data bit k SHALL be sampled at t0+DIV/2+(k+1)*DIV into bit k of the shift register; after bit N-1 -> STOP.
REQ-017 STOP: rxs sampled at t0+DIV/2+(N+1)*DIV; 1 -> frame good, state IDLE; 0 -> frame_err pulse next cycle, frame discarded, -> WAIT_IDLE.
REQ-018 WAIT_IDLE: remain until rxs==1, then -> IDLE.
REQ-019 Good frame with valid==0: out loaded, valid high from the cycle after the stop sample (latency 1).
REQ-020 Good frame with valid==1 and no ack that cycle: out unchanged, valid stays 1, overrun pulses one cycle.
REQ-021 ack with valid==1 SHALL clear valid next cycle; ack with valid==0 ignored.
REQ-022 ack and good-frame completion same cycle: new data loaded, valid stays 1, no overrun.
REQ-023 out SHALL change only on a good-frame load or reset.
REQ-024 Tick counter width clog2(DIV); bit counter width clog2(N+1); counters wrap to 0 on each bit sample, never free-run.

Reset
REQ-025 On res==0: state IDLE, out=0, valid=0, busy=0, frame_err=0, overrun=0, counters and shift register 0, synchronizer flops 1.
REQ-026 Reset mid-frame SHALL abandon the frame with no pulses; reception restarts on the next start edge after res==1.

Structure
REQ-027 Package sipo_rx_pkg SHALL hold the state enum type and default N/DIV constants.
REQ-028 One sub-module, rx_shift_reg (N-bit, enable-gated, bit-index write, synchronous clear), SHALL hold the data bits; sipo_rx_ctrl SHALL sequence it.

Verification (N=10, DIV=16)
REQ-029 Frame data 10'h2A5, stop 1 -> out=10'h2A5, valid high at t0+185, busy low after stop sample.
REQ-030 rxs low 3 cycles then high -> returns IDLE at t0+8, valid/frame_err/overrun stay 0.
REQ-031 Frame 10'h155 with stop 0 -> frame_err one pulse, out unchanged, no new frame accepted until rx high.
REQ-032 Frames 10'h001 then 10'h3FF, no ack -> out=10'h001, overrun one pulse at second frame end; ack -> valid 0.
REQ-033 res low during data bit 5, then frame 10'h0F0 -> all outputs 0 during reset, then out=10'h0F0, valid 1.
REQ-034 ack asserted exactly on 10'h0AA completion with 10'h111 pending -> out=10'h0AA, valid 1, overrun 0.

Source files
------------

// File: rtl/sipo_rx_pkg.sv
// Shared definitions for the serial-in / parallel-out receiver.
//   DefN    : default data bits per frame
//   DefDiv  : default clock cycles per serial bit
//   state_e : receiver FSM state encoding
package sipo_rx_pkg;

  localparam int unsigned DefN   = 10;
  localparam int unsigned DefDiv = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StShift,
    StStop,
    StWaitIdle
  } state_e;

endpackage

// File: rtl/rx_shift_reg.sv
// Data-bit holding register for the receiver.
// Each enabled cycle writes din into bit idx; clr zeroes the whole register.
//   clk  : clock (rising edge)
//   res  : synchronous active-low reset
//   clr  : synchronous clear (wins over en)
//   en   : write enable for bit idx
//   idx  : bit index to write
//   din  : serial data bit
//   q    : held data bits
module rx_shift_reg #(
  parameter int unsigned N  = 10,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          res,
  input  logic          clr,
  input  logic          en,
  input  logic [IW-1:0] idx,
  input  logic          din,
  output logic [N-1:0]  q
);

  logic [N-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!res) begin
      data_q <= '0;
    end else if (clr) begin
      data_q <= '0;
    end else if (en) begin
      data_q[idx] <= din;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Serial frame receiver: start bit, N data bits LSB first, stop bit.
// Each bit is sampled mid-cell, DIV cycles apart, after the start edge is seen.
//   clk       : clock (rising edge)
//   res       : synchronous active-low reset
//   rx        : asynchronous serial line, idle high
//   ack       : consumer accepts out while valid is high
//   out       : data of the last good frame
//   valid     : out holds an unconsumed frame
//   busy      : receiver is not idle
//   frame_err : one-cycle pulse after a bad stop bit
//   overrun   : one-cycle pulse when a good frame is dropped
module sipo_rx_ctrl
  import sipo_rx_pkg::*;
#(
  parameter int unsigned N   = DefN,
  parameter int unsigned DIV = DefDiv
) (
  input  logic         clk,
  input  logic         res,
  input  logic         rx,
  input  logic         ack,
  output logic [N-1:0] out,
  output logic         valid,
  output logic         busy,
  output logic         frame_err,
  output logic         overrun
);

  localparam int unsigned TW = $clog2(DIV);
  localparam int unsigned BW = $clog2(N + 1);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [TW-1:0] TickHalf = TW'(DIV / 2 - 1);
  localparam logic [TW-1:0] TickFull = TW'(DIV - 1);
  localparam logic [BW-1:0] BitLast  = BW'(N - 1);

  logic          sync1_q, rxs_q;
  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [N-1:0]  out_q;
  logic          valid_q, ferr_q, ovr_q;
  logic          sr_clr, sr_en, good, bad;
  logic [N-1:0]  sr_q;

  rx_shift_reg #(
    .N  (N),
    .IW (IW)
  ) u_shift (
    .clk (clk),
    .res (res),
    .clr (sr_clr),
    .en  (sr_en),
    .idx (bit_q[IW-1:0]),
    .din (rxs_q),
    .q   (sr_q)
  );

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    sr_clr  = 1'b0;
    sr_en   = 1'b0;
    good    = 1'b0;
    bad     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rxs_q) begin
          state_d = StStart;
          tick_d  = '0;
          sr_clr  = 1'b1;
        end
      end
      StStart: begin
        // Re-check the start bit in mid-cell; a high line here was a glitch.
        if (tick_q == TickHalf) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = rxs_q ? StIdle : StShift;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      StShift: begin
        if (tick_q == TickFull) begin
          tick_d = '0;
          sr_en  = 1'b1;
          if (bit_q == BitLast) begin
            bit_d   = '0;
            state_d = StStop;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      StStop: begin
        if (tick_q == TickFull) begin
          tick_d = '0;
          if (rxs_q) begin
            good    = 1'b1;
            state_d = StIdle;
          end else begin
            bad     = 1'b1;
            state_d = StWaitIdle;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      StWaitIdle: begin
        // A broken frame may leave the line low; wait for idle before re-arming.
        if (rxs_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= StIdle;
      tick_q  <= '0;
      bit_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      ferr_q  <= bad;
      // A same-cycle ack frees the holding register, so the new frame is kept.
      ovr_q   <= good && valid_q && !ack;
      if (good && (!valid_q || ack)) begin
        out_q   <= sr_q;
        valid_q <= 1'b1;
      end else if (ack && valid_q) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out       = out_q;
  assign valid     = valid_q;
  assign busy      = (state_q != StIdle);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule
